// File: rtl/ttl_7404_pkg.sv
// Purpose : shared types and elaboration helpers for the ttl_7404 hex inverter.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
//
// Contents:
//   edge_dir_t  - direction of the transition a bit is currently timing
//   max_int     - larger of two elaboration-time integers
//   cnt_width   - counter width able to hold the larger of the two delays
package ttl_7404_pkg;

    // Direction of the output transition a bit is working towards.
    // EDGE_NONE means the sampled target already matches the output.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_dir_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter only has to reach max(delay)-1 before it is cleared, but sizing
    // for max(delay) keeps the +1 compare free of overflow corner cases.
    function automatic int cnt_width(input int rise, input int fall);
        int w;
        w = $clog2(max_int(rise, fall) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ttl_delay_bit.sv
// Purpose : one inverter gate with inertial rise/fall delay counted in clocks.
// Latency : y follows ~a after DELAY_RISE (0->1) or DELAY_FALL (1->0) edges.
// Backpr. : none; pulses shorter than the relevant delay are swallowed.
//
// Ports:
//   clk - clock, all state updates on rising edge
//   rst - synchronous active-high reset; loads y = ~a and clears the counter
//   a   - gate input
//   y   - registered gate output
module ttl_delay_bit
    import ttl_7404_pkg::*;
#(
    parameter int DELAY_RISE = 1,
    parameter int DELAY_FALL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic y
);

    localparam int CNT_W = cnt_width(DELAY_RISE, DELAY_FALL);

    // Delays resized once so the compare below is width-matched.
    localparam int             RISE_INT = DELAY_RISE;
    localparam int             FALL_INT = DELAY_FALL;
    localparam logic [CNT_W:0] RISE_CNT = RISE_INT[CNT_W:0];
    localparam logic [CNT_W:0] FALL_CNT = FALL_INT[CNT_W:0];

    logic             y_q;
    logic             y_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             target;
    edge_dir_t        edge_dir;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   delay_sel;

    // Work out which way (if any) the output wants to move and how long
    // that direction has to be held before it is allowed to commit.
    always_comb begin
        target    = ~a;
        edge_dir  = EDGE_NONE;
        if (target != y_q) begin
            edge_dir = target ? EDGE_RISE : EDGE_FALL;
        end
        delay_sel = (edge_dir == EDGE_RISE) ? RISE_CNT : FALL_CNT;
        cnt_inc   = {1'b0, cnt_q} + 1'b1;
    end

    // Inertial filter: any edge where the target agrees with the output
    // discards partial progress, so only an unbroken run of disagreeing
    // samples of the required length moves the output.
    always_comb begin
        y_d   = y_q;
        cnt_d = '0;
        case (edge_dir)
            EDGE_RISE,
            EDGE_FALL: begin
                if (cnt_inc == delay_sel) begin
                    y_d   = target;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                y_d   = y_q;
                cnt_d = '0;
            end
        endcase
    end

    // Reset snaps the output straight to ~a so no transition is left pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= ~a;
            cnt_q <= '0;
        end else begin
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/ttl_7404.sv
// Purpose : parameterised hex inverter (7404 family) with clocked rise/fall delays.
// Latency : Y[i] settles to ~A[i] after DELAY_RISE / DELAY_FALL stable edges.
// Backpr. : none; every bit filters its own short pulses independently.
//
// Ports:
//   clk - clock, all state updates on rising edge
//   rst - synchronous active-high reset; Y loads ~A immediately
//   A   - BLOCKS gate inputs
//   Y   - BLOCKS registered gate outputs, driven directly from flops
module ttl_7404
    import ttl_7404_pkg::*;
#(
    parameter int BLOCKS     = 6,
    parameter int DELAY_RISE = 1,
    parameter int DELAY_FALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BLOCKS-1:0] A,
    output logic [BLOCKS-1:0] Y
);

    // Each gate is fully independent; no state is shared between bits.
    for (genvar g = 0; g < BLOCKS; g++) begin : g_gate
        ttl_delay_bit #(
            .DELAY_RISE (DELAY_RISE),
            .DELAY_FALL (DELAY_FALL)
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .a   (A[g]),
            .y   (Y[g])
        );
    end

endmodule

// File: tb/tb_ttl_7404.sv
module tb_ttl_7404;

    localparam int BLOCKS = 7;
    localparam int DR     = 2;
    localparam int DF     = 3;
    localparam int MAXD   = (DR > DF) ? DR : DF;

    logic              clk;
    logic              rst;
    logic [BLOCKS-1:0] A;
    logic [BLOCKS-1:0] Y;

    ttl_7404 #(
        .BLOCKS     (BLOCKS),
        .DELAY_RISE (DR),
        .DELAY_FALL (DF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .Y   (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference model: a bit's output moves to the opposite value exactly
    // when the most recent D sampled targets (~A) all equal that opposite
    // value.  Any sample agreeing with the output breaks the window, so
    // the window never spans an earlier output change.
    logic [BLOCKS-1:0] hist [MAXD];
    logic [BLOCKS-1:0] ym;

    task automatic model_edge(input logic r, input logic [BLOCKS-1:0] a);
        logic tgt;
        int   d;
        logic all_same;
        for (int k = MAXD - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = ~a;
        if (r) begin
            ym = ~a;
        end else begin
            for (int i = 0; i < BLOCKS; i++) begin
                tgt      = ~ym[i];
                d        = tgt ? DR : DF;
                all_same = 1'b1;
                for (int k = 0; k < d; k++)
                    if (hist[k][i] !== tgt) all_same = 1'b0;
                if (all_same) ym[i] = tgt;
            end
        end
    endtask

    task automatic check(input string name, input logic [BLOCKS-1:0] got,
                         input logic [BLOCKS-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: Y=%b expected=%b", name, got, exp);
        end
    endtask

    // One rising edge with the given inputs; outputs are read on the
    // following falling edge.
    task automatic apply(input logic r, input logic [BLOCKS-1:0] a);
        rst = r;
        A   = a;
        @(posedge clk);
        model_edge(r, a);
        @(negedge clk);
    endtask

    typedef struct {
        logic              r;
        logic [BLOCKS-1:0] a;
        logic [BLOCKS-1:0] y_exp;
        string             name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [BLOCKS-1:0] a,
                                input logic [BLOCKS-1:0] y, input string n);
        vec_t v;
        v.r = r; v.a = a; v.y_exp = y; v.name = n;
        return v;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        A     = '0;
        for (int k = 0; k < MAXD; k++) hist[k] = '0;
        ym = '0;
        @(negedge clk);

        // reset and hold
        vecs.push_back(mk(1'b1, 7'h7F, 7'h00, "reset_all_high"));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1'b0, 7'h7F, 7'h00, "hold_after_reset"));
        // single rising bits, rise delay 2
        vecs.push_back(mk(1'b0, 7'h7D, 7'h00, "bit1_rise_edge1"));
        vecs.push_back(mk(1'b0, 7'h7D, 7'h02, "bit1_rise_edge2"));
        vecs.push_back(mk(1'b0, 7'h3D, 7'h02, "bit6_rise_edge1"));
        vecs.push_back(mk(1'b0, 7'h3D, 7'h42, "bit6_rise_edge2"));
        // all rise, then bit3 falls with delay 3
        vecs.push_back(mk(1'b0, 7'h00, 7'h42, "all_rise_edge1"));
        vecs.push_back(mk(1'b0, 7'h00, 7'h7F, "all_rise_edge2"));
        vecs.push_back(mk(1'b0, 7'h00, 7'h7F, "all_rise_hold"));
        vecs.push_back(mk(1'b0, 7'h08, 7'h7F, "bit3_fall_edge1"));
        vecs.push_back(mk(1'b0, 7'h08, 7'h7F, "bit3_fall_edge2"));
        vecs.push_back(mk(1'b0, 7'h08, 7'h77, "bit3_fall_edge3"));
        // multi-bit pattern changes
        vecs.push_back(mk(1'b0, 7'h2D, 7'h77, "pat1_edge1"));
        vecs.push_back(mk(1'b0, 7'h2D, 7'h77, "pat1_edge2"));
        vecs.push_back(mk(1'b0, 7'h2D, 7'h52, "pat1_edge3"));
        vecs.push_back(mk(1'b0, 7'h52, 7'h52, "pat2_edge1"));
        vecs.push_back(mk(1'b0, 7'h52, 7'h7F, "pat2_rises_edge2"));
        vecs.push_back(mk(1'b0, 7'h52, 7'h2D, "pat2_falls_edge3"));
        // back to all-high inputs
        vecs.push_back(mk(1'b0, 7'h7F, 7'h2D, "settle_low_edge1"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h2D, "settle_low_edge2"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h00, "settle_low_edge3"));
        // inertial filter: 1-cycle pulse swallowed
        vecs.push_back(mk(1'b0, 7'h7E, 7'h00, "pulse1_low"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h00, "pulse1_back"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h00, "pulse1_quiet"));
        // 2-cycle pulse passes, then fall path clears after 3 edges
        vecs.push_back(mk(1'b0, 7'h7E, 7'h00, "pulse2_edge1"));
        vecs.push_back(mk(1'b0, 7'h7E, 7'h01, "pulse2_edge2"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h01, "pulse2_back1"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h01, "pulse2_back2"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h00, "pulse2_back3"));
        // reset mid-transition
        vecs.push_back(mk(1'b0, 7'h7B, 7'h00, "midrst_start"));
        vecs.push_back(mk(1'b1, 7'h7B, 7'h04, "midrst_reset_edge"));
        vecs.push_back(mk(1'b0, 7'h7B, 7'h04, "midrst_hold1"));
        vecs.push_back(mk(1'b0, 7'h7B, 7'h04, "midrst_hold2"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h04, "midrst_fall1"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h04, "midrst_fall2"));
        vecs.push_back(mk(1'b0, 7'h7F, 7'h00, "midrst_fall3"));
        // reset must discard a partial count
        vecs.push_back(mk(1'b0, 7'h7B, 7'h00, "cntclr_partial"));
        vecs.push_back(mk(1'b1, 7'h7F, 7'h00, "cntclr_reset"));
        vecs.push_back(mk(1'b0, 7'h7B, 7'h00, "cntclr_edge1"));
        vecs.push_back(mk(1'b0, 7'h7B, 7'h04, "cntclr_edge2"));

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].a);
            check(vecs[i].name, Y, vecs[i].y_exp);
        end

        // Randomised phase against the window model; bits toggle sparsely
        // so both short pulses and settled transitions occur.
        begin
            logic [BLOCKS-1:0] a_r;
            logic              r_r;
            a_r = A;
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < BLOCKS; i++)
                    if ($urandom_range(0, 3) == 0) a_r[i] = ~a_r[i];
                r_r = ($urandom_range(0, 60) == 0);
                apply(r_r, a_r);
                check("random_vs_model", Y, ym);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ttl_7404.md
Name: ttl_7404

Overview:
- Parameterised hex inverter (7404 family) modelled as synchronous logic with per-bit rise/fall propagation delays counted in clock cycles.
- Each output bit is the logical inverse of its input bit, updated only after the input has been stable for the edge-specific delay.
- Used as a drop-in glue-logic cell in clocked TTL-equivalent datapaths.

Parameters:
- BLOCKS, 6, number of independent inverter gates (bit width of A and Y); must be ≥1.
- DELAY_RISE, 1, clock cycles for a Y bit to go 0→1 after its A bit goes 1→0; must be ≥1.
- DELAY_FALL, 1, clock cycles for a Y bit to go 1→0 after its A bit goes 0→1; must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- A  input  BLOCKS  gate inputs, one bit per inverter.
- Y  output  BLOCKS  gate outputs; registered; Y[i] settles to ~A[i].

Behaviour:
- One clock domain; reset is synchronous and active-high (clk, rst).
- Reset: at a rising edge with rst=1, Y loads ~A with no delay and all per-bit delay counters clear to 0. No pending transitions survive reset. This also applies to a reset asserted mid-transition.
- Bits are fully independent. A change on A[j] never affects Y[i] timing for i≠j.
- Per bit i, at each rising edge with rst=0, let T = ~A[i] as sampled at that edge:
  - If T == Y[i]: counter[i] ← 0 and Y[i] holds. This is inertial behaviour: a pulse shorter than the delay is swallowed.
  - If T != Y[i]: let D = DELAY_RISE when T=1, else DELAY_FALL.
    - If counter[i]+1 == D: Y[i] ← T and counter[i] ← 0.
    - Otherwise counter[i] ← counter[i]+1 and Y[i] holds.
- Net effect: Y[i] changes at the D-th consecutive rising edge at which the sampled ~A[i] differs from Y[i].
  - D=1 gives a plain one-cycle registered inverter.
- Counter width: $clog2(max(DELAY_RISE, DELAY_FALL)+1). There is no wrap-around, because the counter is cleared on reaching D.
- Simultaneous changes on multiple bits proceed in parallel with their own delays. A rising bit and a falling bit changed at the same edge complete DELAY_RISE and DELAY_FALL edges later respectively.
- No combinational path from A to Y. Y is driven directly from flops.
- Undefined (X) inputs are not specially handled.

Decomposition:
- No shared package required. The delay-width constant is a localparam inside the module.
- One natural sub-module: ttl_delay_bit, a single inverter bit with its counter and inertial filter, parameterised by DELAY_RISE/DELAY_FALL. ttl_7404 instantiates it BLOCKS times via generate.

Test Plan (BLOCKS=7, DELAY_RISE=2, DELAY_FALL=3):
- Reset with A=7'b1111111, then hold A 5 cycles → Y=7'b0000000 immediately after the reset edge and throughout.
- A[1]←0, others 1 → Y[1]=0 after 1 edge, Y[1]=1 after 2nd edge. Then A[6]←0 → Y=7'b1000010 after 2 more edges. All other bits stay 0 throughout.
- All A←0 and hold → Y=7'b1111111 within 2 edges. Then A[3]←1 → Y[3] still 1 after 2 edges, Y=7'b1110111 after the 3rd edge.
- A=7'b0101101 from Y=7'b1110111, then A=7'b1010010 after settling:
  - First change → Y=7'b1010010 (==~A) by 3 edges.
  - Second change → Y=7'b0101101 (==~A) by 3 edges. Rising bits flip at edge 2, falling bits at edge 3.
- Inertial filter: from A[0]=1 (Y[0]=0), pulse A[0]=0 for 1 cycle, then back to 1 → Y[0] never changes. A 2-cycle pulse → Y[0] is 1 for exactly the cycles until the fall path re-clears it (3 edges after A[0] returns to 1).
- Reset mid-transition: A[2] 1→0, assert rst on the next edge → Y[2]=1 immediately at that reset edge, counter 0, no further toggles.
